// File: rtl/jtag_sba_mem_slave_if.sv
// Request/grant/rvalid bus between the JTAG system-bus-access master and a memory responder.
interface jtag_sba_mem_slave_if;
   logic        req;
   logic        gnt;
   logic        rvalid;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/jtag_sba_mem_slave.sv
// Word-addressed RAM responder for the SBA req/gnt/rvalid bus with programmable grant wait-states.
// Out-of-window or misaligned accesses complete with err and leave the RAM untouched.
module jtag_sba_mem_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 64,
   parameter int          GNT_WAIT    = 0
) (
   input logic                 clk,
   input logic                 rst_n,
   jtag_sba_mem_slave_if.slave slave
);
   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
   localparam logic [3:0]  WAIT_LOAD = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e             state_q;
   state_e             state_d;
   logic [3:0]         cnt_q;
   logic [3:0]         cnt_d;
   logic               gnt_s;
   logic               hs_s;
   logic               err_s;
   logic [31:0]        off_s;
   logic [IDX_W-1:0]   idx_s;
   logic               rvalid_q;
   logic               rvalid_d;
   logic [31:0]        rdata_q;
   logic [31:0]        rdata_d;
   logic               err_q;
   logic               err_d;
   logic [31:0]        mem_q [DEPTH_WORDS];

   // Decode: the 33-bit upper bound keeps a window ending at the top of the address space from wrapping.
   always_comb begin
      off_s = slave.addr - BASE_ADDR;
      idx_s = IDX_W'(off_s >> 2);
      err_s = (slave.addr[1:0] != 2'b00) ||
              (slave.addr < BASE_ADDR) ||
              ({1'b0, slave.addr} >= LIMIT);
   end

   // Grant FSM: a dropped request in WAIT is an abort and restarts the full wait next time.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (slave.req) begin
               if (GNT_WAIT == 0) begin
                  gnt_s = 1'b1;
               end else begin
                  cnt_d   = WAIT_LOAD;
                  state_d = ST_WAIT;
               end
            end else begin
               cnt_d = 4'd0;
            end
         end
         ST_WAIT: begin
            if (!slave.req) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               gnt_s   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign hs_s      = slave.req & gnt_s;
   assign slave.gnt = gnt_s;

   // Response for the handshake of this cycle; data and err stay zero outside rvalid.
   always_comb begin
      rvalid_d = hs_s;
      rdata_d  = 32'h0000_0000;
      err_d    = 1'b0;
      if (hs_s) begin
         if (err_s) begin
            err_d = 1'b1;
         end else if (!slave.we) begin
            rdata_d = mem_q[idx_s];
         end else begin
            rdata_d = 32'h0000_0000;
         end
      end else begin
         rvalid_d = 1'b0;
      end
   end

   // RAM byte-lane writes; contents survive reset.
   always_ff @(posedge clk) begin
      if (hs_s && slave.we && !err_s) begin
         for (int b = 0; b < 4; b++) begin
            if (slave.be[b]) begin
               mem_q[idx_s][8*b +: 8] <= slave.wdata[8*b +: 8];
            end
         end
      end
   end

   // State and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign slave.rvalid = rvalid_q;
   assign slave.rdata  = rdata_q;
   assign slave.err    = err_q;
endmodule

// File: tb/tb_jtag_sba_mem_slave.sv
// Randomized bench for jtag_sba_mem_slave: a zero-wait instance checked against an array model,
// plus a three-wait-state instance for grant timing and abort behaviour.
module tb_jtag_sba_mem_slave;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 64;
   localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   jtag_sba_mem_slave_if bus0 ();
   jtag_sba_mem_slave_if bus3 ();

   jtag_sba_mem_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .GNT_WAIT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .slave(bus0));
   jtag_sba_mem_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .GNT_WAIT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .slave(bus3));

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t        stim [$];
   logic [31:0] model_mem [DEPTH];

   // Reference: window/alignment rules in plain arithmetic, RAM as an array of words.
   function automatic void model_access(input req_t r, output logic exp_err, output logic [31:0] exp_rdata);
      longint unsigned a;
      longint unsigned lo;
      longint unsigned hi;
      int              idx;
      a         = {32'h0, r.addr};
      lo        = {32'h0, BASE};
      hi        = lo + 4 * DEPTH;
      exp_err   = (a % 4 != 0) || (a < lo) || (a >= hi);
      exp_rdata = 32'h0;
      if (!exp_err) begin
         idx = int'((a - lo) / 4);
         if (r.we) begin
            for (int b = 0; b < 4; b++) begin
               if (r.be[b]) model_mem[idx][8*b +: 8] = r.wdata[8*b +: 8];
            end
         end else begin
            exp_rdata = model_mem[idx];
         end
      end
   endfunction

   function automatic logic [31:0] word_addr(input int idx);
      return BASE + 32'(4 * idx);
   endfunction

   function automatic logic [31:0] rand_addr();
      int          k;
      logic [31:0] a;
      k = int'($urandom_range(0, 9));
      case (k)
         0:       a = TOP + 32'(4 * $urandom_range(0, 15));
         1:       a = BASE - 32'(4 * $urandom_range(1, 16));
         2:       a = word_addr(int'($urandom_range(0, DEPTH - 1))) + 32'($urandom_range(1, 3));
         3:       a = $urandom();
         default: a = word_addr(int'($urandom_range(0, DEPTH - 1)));
      endcase
      return a;
   endfunction

   function automatic req_t mk(input logic req, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
      req_t r;
      r.req = req; r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   // Plays the queued requests on the zero-wait instance, one per cycle, checking gnt and the response.
   task automatic run_stream(input string tag);
      logic        pend;
      logic        pend_err;
      logic [31:0] pend_rdata;
      logic        e;
      logic [31:0] d;
      req_t        r;
      int          n;
      pend = 1'b0; pend_err = 1'b0; pend_rdata = 32'h0;
      n = stim.size();
      for (int i = 0; i <= n; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus0.rvalid !== pend || bus0.err !== (pend & pend_err) ||
             bus0.rdata !== (pend ? pend_rdata : 32'h0)) begin
            n_bad++;
            $display("FAIL %s_resp[%0d]: rvalid/err/rdata got %b/%b/%h want %b/%b/%h", tag, i,
                     bus0.rvalid, bus0.err, bus0.rdata, pend, pend & pend_err, pend ? pend_rdata : 32'h0);
         end
         if (i < n) begin
            r = stim[i];
            bus0.req = r.req; bus0.we = r.we; bus0.be = r.be; bus0.addr = r.addr; bus0.wdata = r.wdata;
            #1;
            n_cmp++;
            if (bus0.gnt !== r.req) begin
               n_bad++;
               $display("FAIL %s_gnt[%0d]: got %b want %b", tag, i, bus0.gnt, r.req);
            end
            pend = r.req;
            if (r.req) begin
               model_access(r, e, d);
               pend_err = e; pend_rdata = d;
            end
         end else begin
            bus0.req = 1'b0;
         end
      end
      stim.delete();
   endtask

   task automatic test_reset();
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.be = 4'h0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
      bus3.req = 1'b0; bus3.we = 1'b0; bus3.be = 4'h0; bus3.addr = 32'h0; bus3.wdata = 32'h0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus0.gnt, bus0.rvalid, bus0.err, bus0.rdata} !== 35'h0) begin
         n_bad++;
         $display("FAIL reset_dut0: gnt/rvalid/err/rdata got %b/%b/%b/%h want all 0",
                  bus0.gnt, bus0.rvalid, bus0.err, bus0.rdata);
      end
      n_cmp++;
      if ({bus3.gnt, bus3.rvalid, bus3.err, bus3.rdata} !== 35'h0) begin
         n_bad++;
         $display("FAIL reset_dut3: gnt/rvalid/err/rdata got %b/%b/%b/%h want all 0",
                  bus3.gnt, bus3.rvalid, bus3.err, bus3.rdata);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) stim.push_back(mk(1'b1, 1'b1, 4'hF, word_addr(i), $urandom()));
      run_stream("fill");
   endtask

   task automatic test_basic();
      stim.push_back(mk(1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF));
      stim.push_back(mk(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0));
      run_stream("basic");
   endtask

   task automatic test_byte_enables();
      stim.push_back(mk(1'b1, 1'b1, 4'hF,    word_addr(5), 32'h1122_3344));
      stim.push_back(mk(1'b1, 1'b1, 4'b0101, word_addr(5), 32'hAABB_CCDD));
      stim.push_back(mk(1'b1, 1'b0, 4'h0,    word_addr(5), 32'h0));
      stim.push_back(mk(1'b1, 1'b1, 4'b0000, word_addr(5), $urandom()));
      stim.push_back(mk(1'b1, 1'b0, 4'h3,    word_addr(5), 32'h0));
      run_stream("byte_en");
   endtask

   task automatic test_errors();
      stim.push_back(mk(1'b1, 1'b1, 4'hF, word_addr(0), $urandom()));
      stim.push_back(mk(1'b1, 1'b1, 4'hF, word_addr(DEPTH - 1), $urandom()));
      stim.push_back(mk(1'b1, 1'b1, 4'hF, TOP, $urandom()));
      stim.push_back(mk(1'b1, 1'b1, 4'hF, BASE - 32'h4, $urandom()));
      stim.push_back(mk(1'b1, 1'b1, 4'hF, BASE + 32'h2, $urandom()));
      stim.push_back(mk(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, $urandom()));
      stim.push_back(mk(1'b1, 1'b0, 4'hF, TOP, 32'h0));
      stim.push_back(mk(1'b1, 1'b0, 4'hF, BASE + 32'h1, 32'h0));
      stim.push_back(mk(1'b1, 1'b0, 4'hF, word_addr(0), 32'h0));
      stim.push_back(mk(1'b1, 1'b0, 4'hF, word_addr(DEPTH - 1), 32'h0));
      run_stream("errors");
   endtask

   task automatic test_back_to_back();
      int idx [8];
      for (int i = 0; i < 8; i++) begin
         idx[i] = int'($urandom_range(0, DEPTH - 1));
         stim.push_back(mk(1'b1, 1'b1, 4'($urandom_range(0, 15)), word_addr(idx[i]), $urandom()));
      end
      stim.push_back(mk(1'b1, 1'b0, 4'hF, word_addr(idx[7]), 32'h0));
      for (int i = 1; i < 8; i++) stim.push_back(mk(1'b1, 1'b0, 4'h0, word_addr(idx[$urandom_range(0, 7)]), 32'h0));
      run_stream("b2b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         stim.push_back(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           rand_addr(), $urandom()));
      end
      run_stream("random");
   endtask

   // Holds req on the wait-state instance for ncyc cycles; gnt is due only in the last one when expect_gnt.
   task automatic hold_req3(input string tag, input int ncyc, input logic expect_gnt);
      for (int c = 1; c <= ncyc; c++) begin
         #1;
         n_cmp++;
         if (bus3.gnt !== (expect_gnt && c == ncyc) || bus3.rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_cycle%0d: gnt/rvalid got %b/%b want %b/0", tag, c,
                     bus3.gnt, bus3.rvalid, expect_gnt && c == ncyc);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] wd;
      logic [31:0] a;
      wd = $urandom();
      a  = word_addr(int'($urandom_range(0, DEPTH - 1)));
      for (int t = 0; t < 2; t++) begin
         @(posedge clk); #1;
         bus3.req = 1'b1; bus3.we = (t == 0); bus3.be = 4'hF; bus3.addr = a; bus3.wdata = wd;
         hold_req3(t == 0 ? "wait_wr" : "wait_rd", 4, 1'b1);
         bus3.req = 1'b0;
         n_cmp++;
         if (bus3.rvalid !== 1'b1 || bus3.err !== 1'b0 || bus3.rdata !== (t == 0 ? 32'h0 : wd)) begin
            n_bad++;
            $display("FAIL wait_resp%0d: rvalid/err/rdata got %b/%b/%h want 1/0/%h", t,
                     bus3.rvalid, bus3.err, bus3.rdata, t == 0 ? 32'h0 : wd);
         end
      end
      @(posedge clk); #1;
      bus3.req = 1'b1; bus3.we = 1'b0;
      hold_req3("abort_req", 2, 1'b0);
      bus3.req = 1'b0;
      hold_req3("abort_idle", 2, 1'b0);
      bus3.req = 1'b1;
      hold_req3("abort_retry", 4, 1'b1);
      bus3.req = 1'b0;
      n_cmp++;
      if (bus3.rvalid !== 1'b1 || bus3.err !== 1'b0 || bus3.rdata !== wd) begin
         n_bad++;
         $display("FAIL abort_retry_resp: rvalid/err/rdata got %b/%b/%h want 1/0/%h",
                  bus3.rvalid, bus3.err, bus3.rdata, wd);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.be = 4'hF; bus0.addr = word_addr(int'($urandom_range(0, DEPTH - 1)));
      #1;
      n_cmp++;
      if (bus0.gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_gnt: got %b want 1", bus0.gnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b0; bus0.req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if ({bus0.gnt, bus0.rvalid, bus0.err, bus0.rdata} !== 35'h0 ||
             {bus3.gnt, bus3.rvalid, bus3.err, bus3.rdata} !== 35'h0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs[%0d]: dut0 rvalid/err/rdata %b/%b/%h dut3 rvalid %b want all 0",
                     c, bus0.rvalid, bus0.err, bus0.rdata, bus3.rvalid);
         end
         @(posedge clk); #1;
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus0.rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_release: rvalid got %b want 0", bus0.rvalid);
      end
      for (int i = 0; i < 8; i++) stim.push_back(mk(1'b1, 1'b0, 4'hF, word_addr(int'($urandom_range(0, DEPTH - 1))), 32'h0));
      run_stream("rst_mid_readback");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_basic();
      test_byte_enables();
      test_errors();
      test_back_to_back();
      test_wait_states();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
